// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the iterative multiply/divide sequencer: op codes,
// FSM state encodings and the operand magnitude helper.
package mdu_ctrl_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

    localparam int         MDU_W         = 32;
    localparam logic [4:0] MDU_LAST_ITER = 5'd31;

    function automatic logic [MDU_W-1:0] absVal(input logic [MDU_W-1:0] v,
                                                input logic             isSigned);
        return (isSigned && v[MDU_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Iterative mult/multu/div/divu sequencer holding HI/LO; 33-cycle latency for every op.
// One 64-bit shift register and one 33-bit adder serve both multiply and divide.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        rd_req,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  r_state;
    mdu_state_e  w_nextState;
    logic [4:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_operand;
    logic [31:0] r_origA;
    logic        r_isDiv;
    logic        r_isSigned;
    logic        r_negMain;
    logic        r_negRem;
    logic        r_divZero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_opIsDiv;
    logic        w_opIsSigned;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [32:0] w_addA;
    logic [32:0] w_addB;
    logic        w_cin;
    logic [32:0] w_sum;
    logic [63:0] w_iterAcc;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_opIsDiv    = op[1];
    assign w_opIsSigned = ~op[0];
    assign w_absA       = absVal(a, w_opIsSigned);
    assign w_absB       = absVal(b, w_opIsSigned);

    // Divide feeds the 33-bit window {rem, next quo bit}; subtraction is A + ~B + 1
    always_comb begin
        w_addA = {1'b0, r_acc[63:32]};
        w_addB = r_acc[0] ? {1'b0, r_operand} : 33'd0;
        w_cin  = 1'b0;
        if (r_isDiv) begin
            w_addA = r_acc[63:31];
            w_addB = ~{1'b0, r_operand};
            w_cin  = 1'b1;
        end
    end

    assign w_sum = w_addA + w_addB + {32'd0, w_cin};

    always_comb begin
        w_iterAcc = {w_sum, r_acc[31:1]};
        if (r_isDiv) begin
            if (w_sum[32]) begin
                w_iterAcc = {r_acc[62:0], 1'b0};
            end else begin
                w_iterAcc = {w_sum[31:0], r_acc[30:0], 1'b1};
            end
        end
    end

    assign w_prod = r_negMain ? -r_acc : r_acc;
    assign w_quo  = r_negMain ? -r_acc[31:0] : r_acc[31:0];
    assign w_rem  = r_negRem ? -r_acc[63:32] : r_acc[63:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            MDU_IDLE: if (start) w_nextState = MDU_RUN;
            MDU_RUN:  if (r_count == MDU_LAST_ITER) w_nextState = MDU_FIX;
            MDU_FIX:  w_nextState = MDU_IDLE;
            default:  w_nextState = MDU_IDLE;
        endcase
    end

    // Sign flags are latched only for signed ops so FIX can apply them unconditionally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= 5'd0;
            r_acc      <= 64'd0;
            r_operand  <= 32'd0;
            r_origA    <= 32'd0;
            r_isDiv    <= 1'b0;
            r_isSigned <= 1'b0;
            r_negMain  <= 1'b0;
            r_negRem   <= 1'b0;
            r_divZero  <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (start) begin
                        r_count    <= 5'd0;
                        r_isDiv    <= w_opIsDiv;
                        r_isSigned <= w_opIsSigned;
                        r_origA    <= a;
                        r_negMain  <= w_opIsSigned & (a[31] ^ b[31]);
                        r_negRem   <= w_opIsSigned & a[31];
                        r_divZero  <= w_opIsDiv & (b == 32'd0);
                        r_acc      <= w_opIsDiv ? {32'd0, w_absA} : {32'd0, w_absB};
                        r_operand  <= w_opIsDiv ? w_absB : w_absA;
                    end else if (mthi) begin
                        r_hi <= wdata;
                    end else if (mtlo) begin
                        r_lo <= wdata;
                    end
                end
                MDU_RUN: begin
                    r_acc   <= w_iterAcc;
                    r_count <= r_count + 5'd1;
                end
                MDU_FIX: begin
                    if (r_isDiv && r_divZero) begin
                        r_hi <= r_origA;
                        r_lo <= 32'hFFFF_FFFF;
                    end else if (r_isDiv) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != MDU_IDLE);
    assign stall = busy & (start | mthi | mtlo | rd_req);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected {hi,lo} queued at issue, popped when busy falls.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        rd_req = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] sbQ[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    mdu_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .rd_req(rd_req),
        .busy  (busy),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] modelOp(input logic [1:0] mOp, input logic [31:0] mA,
                                            input logic [31:0] mB);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(mA));
        sb = longint'($signed(mB));
        case (mOp)
            2'b00: return sa * sb;
            2'b01: return {32'd0, mA} * {32'd0, mB};
            2'b10: begin
                if (mB == 32'd0) return {mA, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (mB == 32'd0) return {mA, 32'hFFFF_FFFF};
                return {mA % mB, mA / mB};
            end
        endcase
    endfunction

    task automatic issueOp(input logic [1:0] iOp, input logic [31:0] iA, input logic [31:0] iB,
                           input logic [63:0] exp, output logic busyAtIssue, output int cycles);
        sbQ.push_back(exp);
        op    = iOp;
        a     = iA;
        b     = iB;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busyAtIssue = busy;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%0b want=0", stall); end
        total++; if (hi !== 32'd0) begin bad++; $display("[TB] FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("[TB] FAIL reset_lo got=%h want=0", lo); end
        #12 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        vec_t vecs[5];
        logic busyAtIssue;
        int cycles;
        logic [63:0] exp;
        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3] = '{2'b11, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        for (int i = 0; i < 5; i++) begin
            issueOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, busyAtIssue, cycles);
            exp = sbQ.pop_front();
            total++; if (busyAtIssue !== 1'b1) begin bad++; $display("[TB] FAIL arith%0d_busy got=%0b want=1", i, busyAtIssue); end
            total++; if (cycles != 33) begin bad++; $display("[TB] FAIL arith%0d_latency got=%0d want=33", i, cycles); end
            total++; if (hi !== exp[63:32]) begin bad++; $display("[TB] FAIL arith%0d_hi got=%h want=%h", i, hi, exp[63:32]); end
            total++; if (lo !== exp[31:0]) begin bad++; $display("[TB] FAIL arith%0d_lo got=%h want=%h", i, lo, exp[31:0]); end
        end
    endtask

    task automatic test_random();
        logic busyAtIssue;
        int cycles;
        logic [63:0] exp;
        logic [1:0] rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        for (int i = 0; i < 8; i++) begin
            rOp = 2'(i % 4);
            rA  = $urandom;
            rB  = (i == 6) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            issueOp(rOp, rA, rB, modelOp(rOp, rA, rB), busyAtIssue, cycles);
            exp = sbQ.pop_front();
            total++; if (cycles != 33) begin bad++; $display("[TB] FAIL rand%0d_latency got=%0d want=33", i, cycles); end
            total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL rand%0d op=%0d a=%h b=%h got=%h want=%h", i, rOp, rA, rB, {hi, lo}, exp); end
        end
    endtask

    task automatic test_hazard();
        int cycles;
        int stallCnt;
        int heldBad;
        logic [31:0] prevLo;
        logic [63:0] exp;
        prevLo = lo;
        sbQ.push_back(64'd42);
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        cycles = 1;
        rd_req = 1'b1;
        #1;
        stallCnt = 0;
        heldBad = 0;
        while (busy === 1'b1 && cycles < 40) begin
            if (stall === 1'b1) stallCnt++;
            if (lo !== prevLo) heldBad++;
            @(posedge clk); #1;
            cycles++;
        end
        exp = sbQ.pop_front();
        total++; if (cycles != 33) begin bad++; $display("[TB] FAIL hazard_latency got=%0d want=33", cycles); end
        total++; if (stallCnt != 32) begin bad++; $display("[TB] FAIL hazard_stall_cycles got=%0d want=32", stallCnt); end
        total++; if (heldBad != 0) begin bad++; $display("[TB] FAIL hazard_lo_held changes=%0d want=0", heldBad); end
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL hazard_stall_release got=%0b want=0", stall); end
        total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL hazard_result got=%h want=%h", {hi, lo}, exp); end
        rd_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cycles;
        int stallCnt;
        logic [63:0] exp;
        sbQ.push_back(64'd6);
        sbQ.push_back({32'd2, 32'd14});
        op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        op = 2'b11; a = 32'd100; b = 32'd7;
        cycles = 0;
        stallCnt = 0;
        while (busy === 1'b1 && cycles < 40) begin
            if (stall === 1'b1) stallCnt++;
            @(posedge clk); #1;
            cycles++;
        end
        exp = sbQ.pop_front();
        total++; if (stallCnt != 33) begin bad++; $display("[TB] FAIL b2b_stall_cycles got=%0d want=33", stallCnt); end
        total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL b2b_first got=%h want=%h", {hi, lo}, exp); end
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept got=%0b want=1", busy); end
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        exp = sbQ.pop_front();
        total++; if (cycles != 33) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=33", cycles); end
        total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL b2b_second got=%h want=%h", {hi, lo}, exp); end
    endtask

    task automatic test_mtlo_mthi();
        int cycles;
        int heldBad;
        int stallMiss;
        logic [31:0] prevHi;
        logic [63:0] exp;
        mtlo = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        mtlo = 1'b0;
        total++; if (lo !== 32'h0000_1234) begin bad++; $display("[TB] FAIL mtlo got=%h want=00001234", lo); end
        prevHi = hi;
        sbQ.push_back(64'd42);
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mthi = 1'b1; wdata = 32'h0000_ABCD;
        #1;
        cycles = 0;
        heldBad = 0;
        stallMiss = 0;
        while (busy === 1'b1 && cycles < 40) begin
            if (stall !== 1'b1) stallMiss++;
            if (hi !== prevHi) heldBad++;
            @(posedge clk); #1;
            cycles++;
        end
        exp = sbQ.pop_front();
        total++; if (stallMiss != 0) begin bad++; $display("[TB] FAIL mthi_stall misses=%0d want=0", stallMiss); end
        total++; if (heldBad != 0) begin bad++; $display("[TB] FAIL mthi_hi_held changes=%0d want=0", heldBad); end
        total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL mthi_op_result got=%h want=%h", {hi, lo}, exp); end
        @(posedge clk); #1;
        mthi = 1'b0;
        total++; if (hi !== 32'h0000_ABCD) begin bad++; $display("[TB] FAIL mthi_late_write got=%h want=0000abcd", hi); end
    endtask

    task automatic test_reset_midrun();
        logic busyAtIssue;
        int cycles;
        logic [63:0] exp;
        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rd_req = 1'b1;
        repeat (9) begin @(posedge clk); #1; end
        total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL midrun_stall_before got=%0b want=1", stall); end
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrun_busy got=%0b want=0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL midrun_stall got=%0b want=0", stall); end
        total++; if (hi !== 32'd0) begin bad++; $display("[TB] FAIL midrun_hi got=%h want=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("[TB] FAIL midrun_lo got=%h want=0", lo); end
        #2 rst = 1'b0;
        rd_req = 1'b0;
        @(posedge clk); #1;
        issueOp(2'b01, 32'd2, 32'd3, 64'd6, busyAtIssue, cycles);
        exp = sbQ.pop_front();
        total++; if (cycles != 33) begin bad++; $display("[TB] FAIL after_reset_latency got=%0d want=33", cycles); end
        total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL after_reset_result got=%h want=%h", {hi, lo}, exp); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_random();
        test_hazard();
        test_back_to_back();
        test_mtlo_mthi();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
